// File: rtl/strobe_generator.sv
// rtl/strobe_generator.sv - per-channel divided reference levels and edge strobes used as clock enables
//
// Purpose:
//   Each channel divides the system clock by a programmable half-period and
//   produces a registered reference level (slowClk) plus a single-cycle strobe
//   on its rising edge, falling edge, or both. Slow peripherals use the strobe
//   as a clock enable, so every flop stays in the clkIn domain.
//
// Parameters:
//   NUM_CH   number of independent channels
//   CNT_W    width of the half-period divide value and of each counter
//   DEF_DIV  divide value loaded into every channel at reset
//
// Ports:
//   clkIn    system clock, all logic on its rising edge
//   reset    asynchronous, active-high reset
//   en       global enable; 0 freezes every channel
//   mode     per channel [2i+1:2i]: 00 off, 01 rising, 10 falling, 11 both
//   divIn    per channel new half-period value, [CNT_W*i +: CNT_W]
//   load     one-cycle request to capture divIn for all channels
//   slowClk  divided reference level per channel
//   strobe   one-cycle pulse on the selected edge(s) of slowClk
//   pending  a loaded divide value is waiting for the next boundary
//
// Optional feature (macro STROBE_EXT_EN):
//   extIn    asynchronous external clock/signal per channel
//   extSel   per channel, 1 derives slowClk from extIn through a 2-flop
//            synchroniser and one edge register instead of the divider

module strobe_generator #(
  parameter int NUM_CH  = 2,
  parameter int CNT_W   = 16,
  parameter int DEF_DIV = 1
) (
  input  logic                    clkIn,
  input  logic                    reset,
  input  logic                    en,
  input  logic [2*NUM_CH-1:0]     mode,
  input  logic [CNT_W*NUM_CH-1:0] divIn,
  input  logic                    load,
`ifdef STROBE_EXT_EN
  input  logic [NUM_CH-1:0]       extIn,
  input  logic [NUM_CH-1:0]       extSel,
`endif
  output logic [NUM_CH-1:0]       slowClk,
  output logic [NUM_CH-1:0]       strobe,
  output logic [NUM_CH-1:0]       pending
);

  localparam logic [1:0] MODE_OFF = 2'b00;

  localparam logic [CNT_W-1:0] DEF_DIV_W = CNT_W'(DEF_DIV);

  // Strobe selection for a toggle leaving level from_level: leaving 0 is a
  // rising edge (mode bit 0), leaving 1 is a falling edge (mode bit 1).
  function automatic logic edge_selected(input logic [1:0] m, input logic from_level);
    return from_level ? m[1] : m[0];
  endfunction

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [1:0]       ch_mode;
    logic [CNT_W-1:0] ch_div_in;

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] act_div;
    logic [CNT_W-1:0] pend_div;
    logic             slow_q;
    logic             strobe_q;
    logic             pend_q;

    logic             ext_sel;
    logic             ext_sync;

    logic             active;
    logic             div_running;
    logic             at_terminal;

    assign ch_mode   = mode[2*i +: 2];
    assign ch_div_in = divIn[CNT_W*i +: CNT_W];

`ifdef STROBE_EXT_EN
    logic sync_1;
    logic sync_2;

    // Two-flop synchroniser; slow_q itself acts as the edge register, so an
    // extIn edge reaches strobe three clocks later.
    always_ff @(posedge clkIn or posedge reset) begin
      if (reset) begin
        sync_1 <= 1'b0;
        sync_2 <= 1'b0;
      end else begin
        sync_1 <= extIn[i];
        sync_2 <= sync_1;
      end
    end

    assign ext_sel  = extSel[i];
    assign ext_sync = sync_2;
`else
    assign ext_sel  = 1'b0;
    assign ext_sync = 1'b0;
`endif

    assign active      = en && (ch_mode != MODE_OFF);
    assign div_running = active && !ext_sel;

    // Greater-or-equal rather than equal: a value applied while the channel is
    // frozen may be smaller than the held count, and the period must end at
    // once instead of wrapping through the whole counter range.
    assign at_terminal = div_running && (cnt >= act_div);

    // Level, counter and strobe.
    always_ff @(posedge clkIn or posedge reset) begin
      if (reset) begin
        cnt      <= '0;
        slow_q   <= 1'b0;
        strobe_q <= 1'b0;
      end else begin
        strobe_q <= 1'b0;
        if (!en) begin
          // Frozen: count and level hold so the period resumes where it stopped.
          cnt    <= cnt;
          slow_q <= slow_q;
        end else if (ch_mode == MODE_OFF) begin
          // Off: restart so the first toggle after enabling is rising.
          cnt    <= '0;
          slow_q <= 1'b0;
        end else if (ext_sel) begin
          cnt    <= '0;
          slow_q <= ext_sync;
          if (ext_sync != slow_q) begin
            strobe_q <= edge_selected(ch_mode, slow_q);
          end
        end else if (at_terminal) begin
          cnt      <= '0;
          slow_q   <= ~slow_q;
          strobe_q <= edge_selected(ch_mode, slow_q);
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end

    // Divide-value handshake. A running divider only switches at a boundary so
    // the current half period is never cut short; a load landing exactly on the
    // boundary goes straight in. An idle divider takes the pending value on the
    // cycle after it was captured.
    always_ff @(posedge clkIn or posedge reset) begin
      if (reset) begin
        act_div  <= DEF_DIV_W;
        pend_div <= '0;
        pend_q   <= 1'b0;
      end else if (at_terminal) begin
        if (load) begin
          act_div <= ch_div_in;
        end else if (pend_q) begin
          act_div <= pend_div;
        end
        pend_q <= 1'b0;
      end else if (load) begin
        // Last load wins while a value is still waiting.
        pend_div <= ch_div_in;
        pend_q   <= 1'b1;
      end else if (pend_q && !div_running) begin
        act_div <= pend_div;
        pend_q  <= 1'b0;
      end
    end

    assign slowClk[i] = slow_q;
    assign strobe[i]  = strobe_q;
    assign pending[i] = pend_q;
  end

endmodule

// File: tb/tb_strobe_generator.sv
// tb/tb_strobe_generator.sv - scoreboard bench for strobe_generator with a behavioural channel model

module tb_strobe_generator;

  localparam int NUM_CH  = 2;
  localparam int CNT_W   = 4;
  localparam int DEF_DIV = 1;

  logic                    clkIn = 1'b0;
  logic                    reset = 1'b0;
  logic                    en    = 1'b0;
  logic [2*NUM_CH-1:0]     mode  = '0;
  logic [CNT_W*NUM_CH-1:0] divIn = '0;
  logic                    load  = 1'b0;
  logic [NUM_CH-1:0]       slowClk;
  logic [NUM_CH-1:0]       strobe;
  logic [NUM_CH-1:0]       pending;
`ifdef STROBE_EXT_EN
  logic [NUM_CH-1:0]       extIn  = '0;
  logic [NUM_CH-1:0]       extSel = '0;
`endif

  always #5 clkIn = ~clkIn;

  strobe_generator #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .DEF_DIV(DEF_DIV)) dut (
    .clkIn   (clkIn),
    .reset   (reset),
    .en      (en),
    .mode    (mode),
    .divIn   (divIn),
    .load    (load),
`ifdef STROBE_EXT_EN
    .extIn   (extIn),
    .extSel  (extSel),
`endif
    .slowClk (slowClk),
    .strobe  (strobe),
    .pending (pending)
  );

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic [NUM_CH-1:0] slow;
    logic [NUM_CH-1:0] strb;
    logic [NUM_CH-1:0] pend;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_x;

  // Behavioural model: cycles elapsed in the current half period, the half
  // period length in use, a waiting length, the output level and the pulse.
  int m_elapsed[NUM_CH];
  int m_half[NUM_CH];
  int m_next[NUM_CH];
  bit m_level[NUM_CH];
  bit m_pulse[NUM_CH];
  bit m_wait[NUM_CH];

  task automatic chk(input string name, input logic [NUM_CH-1:0] got, input logic [NUM_CH-1:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s t=%0t got=%b want=%b", name, $time, got, want);
    end
  endtask

  function automatic void model_reset();
    for (int c = 0; c < NUM_CH; c++) begin
      m_elapsed[c] = 0;
      m_half[c]    = DEF_DIV;
      m_next[c]    = 0;
      m_level[c]   = 1'b0;
      m_pulse[c]   = 1'b0;
      m_wait[c]    = 1'b0;
    end
  endfunction

  function automatic void model_step(input bit e, input logic [2*NUM_CH-1:0] md,
                                     input logic [CNT_W*NUM_CH-1:0] dv, input bit ld);
    for (int c = 0; c < NUM_CH; c++) begin
      int m;
      int d;
      bit running;
      bit boundary;
      m        = int'(md[2*c +: 2]);
      d        = int'(dv[CNT_W*c +: CNT_W]);
      running  = e && (m != 0);
      boundary = running && (m_elapsed[c] >= m_half[c]);
      m_pulse[c] = 1'b0;
      if (e && m == 0) begin
        m_elapsed[c] = 0;
        m_level[c]   = 1'b0;
      end else if (boundary) begin
        m_pulse[c]   = (m_level[c] == 1'b0) ? (m == 1 || m == 3) : (m == 2 || m == 3);
        m_level[c]   = !m_level[c];
        m_elapsed[c] = 0;
      end else if (running) begin
        m_elapsed[c] = m_elapsed[c] + 1;
      end
      if (boundary) begin
        if (ld) m_half[c] = d;
        else if (m_wait[c]) m_half[c] = m_next[c];
        m_wait[c] = 1'b0;
      end else if (ld) begin
        m_next[c] = d;
        m_wait[c] = 1'b1;
      end else if (m_wait[c] && !running) begin
        m_half[c] = m_next[c];
        m_wait[c] = 1'b0;
      end
    end
  endfunction

  function automatic exp_t model_out();
    exp_t x;
    for (int c = 0; c < NUM_CH; c++) begin
      x.slow[c] = m_level[c];
      x.strb[c] = m_pulse[c];
      x.pend[c] = m_wait[c];
    end
    return x;
  endfunction

  // One clock: drive inputs just after the previous edge, let the edge take
  // them, and push what the model expects to be visible afterwards.
  task automatic cycle(input bit e, input logic [2*NUM_CH-1:0] md,
                       input logic [CNT_W*NUM_CH-1:0] dv, input bit ld);
    #1;
    en = e; mode = md; divIn = dv; load = ld;
    @(posedge clkIn);
    model_step(e, md, dv, ld);
    sb_q.push_back(model_out());
  endtask

  task automatic settle();
    @(negedge clkIn);
    #1;
  endtask

  always @(negedge clkIn) begin
    if (sb_q.size() > 0) begin
      mon_x = sb_q.pop_front();
      chk("sb_slowClk", slowClk, mon_x.slow);
      chk("sb_strobe",  strobe,  mon_x.strb);
      chk("sb_pending", pending, mon_x.pend);
    end
  end

  initial begin
    int pulses;
    int first_pulse;
    int guard;
    logic [NUM_CH-1:0] held;

    // Reset state.
    #1 reset = 1'b1;
    #1;
    chk("reset_slowClk", slowClk, '0);
    chk("reset_strobe",  strobe,  '0);
    chk("reset_pending", pending, '0);
    model_reset();
    @(posedge clkIn);
    #1 reset = 1'b0;

    // ch0 rising only at DEF_DIV: toggles every 2 cycles, pulses every 4.
    pulses = 0;
    first_pulse = -1;
    for (int k = 1; k <= 12; k++) begin
      cycle(1'b1, 4'b1101, 8'h00, 1'b0);
      settle();
      if (strobe[0]) begin
        pulses++;
        if (first_pulse < 0) first_pulse = k;
        chk("rise_only_level", slowClk & 2'b01, 2'b01);
      end
    end
    chk("t1_pulse_count", 2'(pulses), 2'd3);
    chk("t1_first_pulse", 2'(first_pulse), 2'd2);

    // Both edges, div=3 on ch0, div=2 on ch1.
    cycle(1'b1, 4'b1111, 8'h23, 1'b1);
    settle();
    chk("load_to_pending", pending, 2'b11);
    for (int k = 0; k < 24; k++) cycle(1'b1, 4'b1111, 8'h00, 1'b0);

    // Mid-period load of 5.
    guard = 0;
    while (m_elapsed[0] != 1 && guard < 20) begin
      cycle(1'b1, 4'b1111, 8'h00, 1'b0);
      guard++;
    end
    chk("midload_sync_bound", 2'(guard < 20), 2'b01);
    cycle(1'b1, 4'b1111, 8'h25, 1'b1);
    settle();
    chk("midload_pending", pending & 2'b01, 2'b01);
    for (int k = 0; k < 20; k++) cycle(1'b1, 4'b1111, 8'h00, 1'b0);

    // Load coincident with terminal count, div 0, both edges.
    guard = 0;
    while (m_elapsed[0] < m_half[0] && guard < 20) begin
      cycle(1'b1, 4'b1111, 8'h00, 1'b0);
      guard++;
    end
    chk("tcload_sync_bound", 2'(guard < 20), 2'b01);
    cycle(1'b1, 4'b1111, 8'h20, 1'b1);
    settle();
    chk("tcload_no_pending", pending & 2'b01, 2'b00);
    for (int k = 0; k < 6; k++) begin
      cycle(1'b1, 4'b1111, 8'h00, 1'b0);
      settle();
      chk("div0_strobe_high", strobe & 2'b01, 2'b01);
    end

    // Enable dropped for 7 cycles mid-count with div 4.
    cycle(1'b1, 4'b1111, 8'h34, 1'b1);
    for (int k = 0; k < 8; k++) cycle(1'b1, 4'b1111, 8'h00, 1'b0);
    guard = 0;
    while (m_elapsed[0] != 2 && guard < 20) begin
      cycle(1'b1, 4'b1111, 8'h00, 1'b0);
      guard++;
    end
    chk("freeze_sync_bound", 2'(guard < 20), 2'b01);
    held = slowClk;
    for (int k = 0; k < 7; k++) begin
      cycle(1'b0, 4'b1111, 8'h00, 1'b0);
      settle();
      chk("freeze_strobe", strobe, 2'b00);
      chk("freeze_level", slowClk, held);
    end
    for (int k = 0; k < 15; k++) cycle(1'b1, 4'b1111, 8'h00, 1'b0);

    // Asynchronous reset mid-count with ch0 high.
    guard = 0;
    while (!(m_level[0] && m_elapsed[0] == 1) && guard < 30) begin
      cycle(1'b1, 4'b1111, 8'h00, 1'b0);
      guard++;
    end
    chk("areset_sync_bound", 2'(guard < 30), 2'b01);
    settle();
    reset = 1'b1;
    #1;
    chk("areset_slowClk", slowClk, '0);
    chk("areset_strobe",  strobe,  '0);
    chk("areset_pending", pending, '0);
    model_reset();
    sb_q.delete();
    @(posedge clkIn);
    #1 reset = 1'b0;

    // Largest divide value, then off and back on.
    cycle(1'b1, 4'b0111, 8'hFF, 1'b1);
    for (int k = 0; k < 40; k++) cycle(1'b1, 4'b0111, 8'h00, 1'b0);
    for (int k = 0; k < 3; k++) cycle(1'b1, 4'b0000, 8'h00, 1'b0);
    for (int k = 0; k < 36; k++) cycle(1'b1, 4'b1110, 8'h00, 1'b0);

    // Randomised traffic.
    begin
      logic [2*NUM_CH-1:0] md;
      md = 4'b1111;
      for (int k = 0; k < 600; k++) begin
        bit e;
        bit ld;
        logic [CNT_W*NUM_CH-1:0] dv;
        e  = ($urandom_range(0, 9) != 0);
        if ($urandom_range(0, 11) == 0) md = 4'($urandom);
        ld = ($urandom_range(0, 6) == 0);
        dv = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom & 32'h33);
        cycle(e, md, dv, ld);
      end
    end

    settle();
    chk("scoreboard_drained", 2'(sb_q.size() == 0), 2'b01);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/strobe_generator.md
# strobe_generator

Parametrised, fully synchronous successor to the delay-based edge-pulse doubler. It produces per-channel divided reference levels and single-cycle strobes on the chosen edges: rising, falling, or both, where both-edges gives the doubled-rate strobe. All outputs are registered in the system clock domain. It feeds clock-enables to slow peripherals (display mux, debouncers, UART bit timing) so that no logic runs on a derived clock.

## Interface
Parameters:
- NUM_CH, 2, number of independent channels
- CNT_W, 16, width of the half-period divide value and counter
- DEF_DIV, 1, divide value loaded into every channel at reset

Ports:
- clkIn  input  1  system clock; all logic on rising edge
- reset  input  1  asynchronous, active-high reset
- en  input  1  global enable; 0 freezes all channels
- mode  input  2*NUM_CH  per channel, bits [2i+1:2i]: 00 off, 01 rising, 10 falling, 11 both edges
- divIn  input  CNT_W*NUM_CH  per channel new half-period value, slice [CNT_W*i +: CNT_W]
- load  input  1  one-cycle request to capture divIn for all channels
- slowClk  output  NUM_CH  divided reference level per channel
- strobe  output  NUM_CH  one-cycle pulse on the selected edge(s) of slowClk
- pending  output  NUM_CH  loaded divide value is waiting for the next boundary

## Operation
- Reset values: slowClk=0, strobe=0, pending=0, counters=0, active divide=DEF_DIV, pending divide=0.
- Per channel, while en=1 and mode!=00:
  - The counter increments each cycle.
  - Terminal count is counter==active divide. At terminal count the counter goes to 0 and slowClk toggles.
  - Half period is (div+1) cycles, full period is 2*(div+1).
- Strobe is registered with slowClk, so it is high in the same cycle slowClk shows the new level:
  - 01: strobe only on 0->1.
  - 10: strobe only on 1->0.
  - 11: strobe on every toggle.
- div=0 gives a toggle every cycle. With mode 11, strobe is then held continuously high.
- mode 00: counter is held at 0, slowClk is forced to 0 next cycle, and strobe is 0. From 00 to active, the first toggle is rising and occurs div+1 cycles later.
- en=0: counters and slowClk hold their values and strobe is 0. Re-enabling resumes from the held count.
- Load handshake:
  - load=1 captures divIn into the pending register and sets pending.
  - The pending value becomes active at the next terminal count, and pending clears then. The current half period is never truncated.
  - A channel with mode 00 or en=0 applies the loaded value on the next cycle.
  - A second load while pending is set overwrites the pending value; the last load wins.
  - load in the same cycle as terminal count: divIn is applied at that boundary and pending stays 0.
- Counter arithmetic is unsigned CNT_W bits. Divide values up to 2^CNT_W-1 are legal and no wrap occurs, because the counter is compared against the active divide before it increments.

## Timing
- Latency from a mode change to its effect: 1 cycle.
- Latency from load to the pending flag: 1 cycle.
- With STROBE_EXT_EN, latency from an extIn edge to strobe: 3 cycles (2-flop synchroniser plus edge register).
- No combinational path from any input to any output.
- Asynchronous reset mid-period clears everything immediately. The first toggle after reset release is rising and comes DEF_DIV+1 cycles after the first enabled cycle.

## Configuration
- STROBE_EXT_EN defined:
  - Adds ports extIn (input, NUM_CH, asynchronous external clock or signal) and extSel (input, NUM_CH).
  - Channel i with extSel=1 derives slowClk from extIn[i] through a 2-flop synchroniser and one edge register; its divider is held at 0.
  - Strobe follows mode on the synchronised edges. Mode 11 on an external clock reproduces the legacy doubler as a clock enable.
- STROBE_EXT_EN undefined: extIn and extSel do not exist, and every channel uses only the internal divider.

## Test plan
- Reset, en=1, mode ch0=01, DEF_DIV=1 -> slowClk0 toggles every 2 cycles; strobe0 pulses every 4 cycles, only on rising.
- mode ch0=11, div=3 -> strobe0 every 4 cycles; each pulse is 1 cycle wide and coincides with each slowClk0 toggle.
- Mid-period load with divIn=5 -> pending=1; the current half period completes at the old length; the next half period is 6 cycles and pending clears.
- load coincident with terminal count, divIn=0, mode 11 -> pending stays 0; strobe is continuously high from the next cycle.
- en dropped for 7 cycles mid-count -> counter and slowClk frozen, strobe 0; the period resumes and completes with the correct remaining count. An async reset asserted mid-count clears all outputs within the same cycle.
- With STROBE_EXT_EN, extSel0=1, mode 11, extIn0 a 10-cycle-period square wave -> strobe0 pulses 3 cycles after each extIn0 edge, 2 pulses per extIn0 period.
